// File: rtl/mofn_stream_checker.sv
// M-of-N code word checker with a one-deep valid/ready output register.
// Tracks a saturating error count, a sticky error flag and a consecutive-error alarm.
module mofn_stream_checker #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned ONES      = 2,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ALARM_RUN = 3
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WIDTH-1:0]             i_value,
    input  logic                         i_clear,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTH-1:0]             o_value,
    output logic                         o_check,
    output logic [$clog2(WIDTH+1)-1:0]   o_ones,
    output logic [CNT_W-1:0]             o_err_count,
    output logic                         o_sticky,
    output logic                         o_alarm
);

    localparam int unsigned ONES_W = $clog2(WIDTH + 1);
    localparam int unsigned RUN_W  = $clog2(ALARM_RUN + 1);
    localparam int unsigned RUN_XW = RUN_W + 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [RUN_XW-1:0] RUN_LIMIT = RUN_XW'(ALARM_RUN);
    localparam logic [ONES_W-1:0] ONES_REQ  = ONES_W'(ONES);

    // Reject parameter sets that cannot describe a meaningful M-of-N code.
    if (ONES == 0 || ONES >= WIDTH) begin : g_bad_ones
        $error("mofn_stream_checker: ONES must satisfy 0 < ONES < WIDTH");
    end
    if (ALARM_RUN == 0 || 64'(ALARM_RUN) >= (64'(1) << CNT_W)) begin : g_bad_alarm_run
        $error("mofn_stream_checker: ALARM_RUN must satisfy 1 <= ALARM_RUN < 2**CNT_W");
    end

    logic              accept;
    logic              pop;
    logic [ONES_W-1:0] pop_cnt;
    logic              bad;

    logic [RUN_W-1:0]  run_q;
    logic [CNT_W-1:0]  err_d;
    logic [RUN_W-1:0]  run_d;
    logic              sticky_d;
    logic              alarm_d;

    logic [CNT_W-1:0]  err_base;
    logic [RUN_W-1:0]  run_base;
    logic              sticky_base;
    logic              alarm_base;
    logic [RUN_XW-1:0] run_inc;

    assign o_ready = ~o_valid | i_ready;
    assign accept  = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    // Population count of the incoming word.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + ONES_W'(i_value[i]);
        end
    end

    assign bad = (pop_cnt != ONES_REQ);

    // Statistics next state: clear applies first, then the accepted word.
    always_comb begin
        err_base    = i_clear ? '0   : o_err_count;
        run_base    = i_clear ? '0   : run_q;
        sticky_base = i_clear ? 1'b0 : o_sticky;
        alarm_base  = i_clear ? 1'b0 : o_alarm;
        run_inc     = RUN_XW'(run_base) + RUN_XW'(1);

        err_d    = err_base;
        run_d    = run_base;
        sticky_d = sticky_base;
        alarm_d  = alarm_base;

        if (accept) begin
            if (bad) begin
                err_d    = (err_base == CNT_MAX) ? err_base : err_base + CNT_W'(1);
                run_d    = (run_inc >= RUN_LIMIT) ? RUN_W'(ALARM_RUN) : run_inc[RUN_W-1:0];
                sticky_d = 1'b1;
                alarm_d  = alarm_base | (run_inc >= RUN_LIMIT);
            end else begin
                run_d    = '0;
            end
        end
    end

    // Output word register; data fields hold their last value after a pop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_value <= '0;
            o_check <= 1'b0;
            o_ones  <= '0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_value <= i_value;
            o_check <= bad;
            o_ones  <= pop_cnt;
        end else if (pop) begin
            o_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_err_count <= '0;
            run_q       <= '0;
            o_sticky    <= 1'b0;
            o_alarm     <= 1'b0;
        end else begin
            o_err_count <= err_d;
            run_q       <= run_d;
            o_sticky    <= sticky_d;
            o_alarm     <= alarm_d;
        end
    end

endmodule

// File: tb/tb_mofn_stream_checker.sv
// Randomised and directed bench for mofn_stream_checker against a queue-free integer model.
module tb_mofn_stream_checker;

    localparam int unsigned W  = 5;
    localparam int unsigned K  = 2;
    localparam int unsigned AR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;
    logic       i_clear = 1'b0;
    logic [4:0] i_value = '0;

    logic       o_ready, o_valid, o_check, o_sticky, o_alarm;
    logic [4:0] o_value;
    logic [2:0] o_ones;
    logic [7:0] o_err_count;

    logic       s_ready, s_valid, s_check, s_sticky, s_alarm;
    logic [4:0] s_value;
    logic [2:0] s_ones;
    logic [1:0] s_err_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit         m_valid;
    logic [4:0] m_value;
    int         m_ones, m_err, m_err2, m_run;
    bit         m_check, m_sticky, m_alarm;

    always #5 clk = ~clk;

    mofn_stream_checker #(.WIDTH(W), .ONES(K), .CNT_W(8), .ALARM_RUN(AR)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_value(i_value), .i_clear(i_clear), .o_valid(o_valid), .i_ready(i_ready),
        .o_value(o_value), .o_check(o_check), .o_ones(o_ones),
        .o_err_count(o_err_count), .o_sticky(o_sticky), .o_alarm(o_alarm)
    );

    mofn_stream_checker #(.WIDTH(W), .ONES(K), .CNT_W(2), .ALARM_RUN(AR)) dut_sat (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(s_ready),
        .i_value(i_value), .i_clear(i_clear), .o_valid(s_valid), .i_ready(i_ready),
        .o_value(s_value), .o_check(s_check), .o_ones(s_ones),
        .o_err_count(s_err_count), .o_sticky(s_sticky), .o_alarm(s_alarm)
    );

    task automatic model_reset();
        m_valid = 0; m_value = '0; m_ones = 0; m_check = 0;
        m_err = 0; m_err2 = 0; m_run = 0; m_sticky = 0; m_alarm = 0;
    endtask

    // Advance one clock with the current inputs and update the model from the rules.
    task automatic tick();
        bit acc, pop, bad;
        int pc;
        logic [4:0] v;
        v   = i_value;
        acc = i_valid && (!m_valid || i_ready);
        pop = m_valid && i_ready;
        pc  = $countones(v);
        bad = (pc != K);
        @(posedge clk);
        if (i_clear) begin
            m_err = 0; m_err2 = 0; m_run = 0; m_sticky = 0; m_alarm = 0;
        end
        if (acc) begin
            m_valid = 1; m_value = v; m_ones = pc; m_check = bad;
            if (bad) begin
                if (m_err < 255) m_err++;
                if (m_err2 < 3) m_err2++;
                m_run = (m_run + 1 > AR) ? AR : m_run + 1;
                m_sticky = 1;
                if (m_run >= AR) m_alarm = 1;
            end else begin
                m_run = 0;
            end
        end else if (pop) begin
            m_valid = 0;
        end
        #1;
    endtask

    function automatic logic [4:0] rand_bad();
        logic [4:0] v;
        v = 5'($urandom);
        while ($countones(v) == K) v = 5'($urandom);
        return v;
    endfunction

    function automatic logic [4:0] rand_good();
        int a, b;
        a = $urandom_range(0, 4);
        b = $urandom_range(0, 3);
        if (b >= a) b++;
        return 5'((1 << a) | (1 << b));
    endfunction

    task automatic test_reset();
        logic [20:0] got;
        model_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        got = {o_valid, o_value, o_check, o_ones, o_err_count, o_sticky, o_alarm, o_ready};
        if (got !== 21'h1) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", got, 21'h1);
        end
        checks++;
        if ({s_valid, s_err_count, s_sticky, s_alarm, s_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_state_sat: got %b want 000001", {s_valid, s_err_count, s_sticky, s_alarm, s_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [4:0] words [4];
        int chk [4], ones [4], err [4], stk [4];
        logic [19:0] got, exp;
        words = '{5'b00011, 5'b10100, 5'b00111, 5'b00000};
        chk   = '{0, 0, 1, 1};
        ones  = '{2, 2, 3, 0};
        err   = '{0, 0, 1, 2};
        stk   = '{0, 0, 1, 1};
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_value = words[i];
            tick();
            got = {o_valid, o_value, o_check, o_ones, o_err_count, o_sticky, o_alarm};
            exp = {1'b1, words[i], 1'(chk[i]), 3'(ones[i]), 8'(err[i]), 1'(stk[i]), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, got, exp);
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_burst_alarm();
        logic [4:0] words [4];
        int alarm [4], err [4];
        words = '{5'b11111, 5'b00001, 5'b01110, 5'b00101};
        alarm = '{0, 0, 1, 1};
        err   = '{1, 2, 3, 3};
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_value = words[i];
            tick();
            checks++;
            if ({o_alarm, o_err_count} !== {1'(alarm[i]), 8'(err[i])}) begin
                errors++;
                $display("FAIL burst_alarm[%0d]: got alarm=%0b err=%0d want alarm=%0d err=%0d",
                         i, o_alarm, o_err_count, alarm[i], err[i]);
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] err0;
        err0 = o_err_count;
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_value = 5'b01001;
        tick();
        checks++;
        if ({o_valid, o_value} !== {1'b1, 5'b01001}) begin
            errors++;
            $display("FAIL bp_first: got valid=%0b value=%b want 1 01001", o_valid, o_value);
        end
        i_value = 5'b11000;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: got %0b want 0", o_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({o_valid, o_value, o_err_count} !== {1'b1, 5'b01001, err0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%0b value=%b err=%0d want 1 01001 %0d",
                         i, o_valid, o_value, o_err_count, err0);
            end
        end
        i_ready = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_high: got %0b want 1", o_ready);
        end
        tick();
        checks++;
        if ({o_valid, o_value, o_err_count} !== {1'b1, 5'b11000, err0}) begin
            errors++;
            $display("FAIL bp_release: got valid=%0b value=%b err=%0d want 1 11000 %0d",
                     o_valid, o_value, o_err_count, err0);
        end
        i_valid = 1'b0;
        tick();
        checks++;
        if ({o_valid, o_value, o_err_count} !== {1'b0, 5'b11000, err0}) begin
            errors++;
            $display("FAIL bp_drain: got valid=%0b value=%b err=%0d want 0 11000 %0d",
                     o_valid, o_value, o_err_count, err0);
        end
    endtask

    task automatic test_saturation();
        int exp2 [5];
        exp2 = '{1, 2, 3, 3, 3};
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_value = rand_bad();
            tick();
            checks++;
            if ({s_err_count, o_err_count} !== {2'(exp2[i]), 8'(i + 1)}) begin
                errors++;
                $display("FAIL saturation[%0d]: got sat=%0d wide=%0d want sat=%0d wide=%0d",
                         i, s_err_count, o_err_count, exp2[i], i + 1);
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_clear_collision();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_value = rand_bad();
            tick();
        end
        checks++;
        if ({o_alarm, o_err_count} !== {1'b1, 8'd3}) begin
            errors++;
            $display("FAIL clear_setup: got alarm=%0b err=%0d want 1 3", o_alarm, o_err_count);
        end
        i_clear = 1'b1;
        i_value = 5'b10000;
        tick();
        i_clear = 1'b0;
        checks++;
        if ({o_err_count, o_sticky, o_alarm, o_check} !== {8'd1, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL clear_collision: got err=%0d sticky=%0b alarm=%0b check=%0b want 1 1 0 1",
                     o_err_count, o_sticky, o_alarm, o_check);
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [19:0] got, exp;
        bit stalled;
        for (int n = 0; n < 400; n++) begin
            stalled = i_valid && !(!m_valid || i_ready);
            if (!stalled) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_value = ($urandom_range(0, 1) != 0) ? rand_good() : 5'($urandom);
            end
            i_ready = ($urandom_range(0, 3) != 0);
            i_clear = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (o_ready !== (!m_valid || i_ready)) begin
                errors++;
                $display("FAIL random_ready[%0d]: got %0b want %0b", n, o_ready, (!m_valid || i_ready));
            end
            tick();
            got = {o_valid, o_value, o_check, o_ones, o_err_count, o_sticky, o_alarm};
            exp = {m_valid, m_value, m_check, 3'(m_ones), 8'(m_err), m_sticky, m_alarm};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_out[%0d]: got %h want %h", n, got, exp);
            end
            checks++;
            if (s_err_count !== 2'(m_err2)) begin
                errors++;
                $display("FAIL random_sat[%0d]: got %0d want %0d", n, s_err_count, m_err2);
            end
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        logic [20:0] got;
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_value = 5'b10001;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: got valid=%0b want 1", o_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        got = {o_valid, o_value, o_check, o_ones, o_err_count, o_sticky, o_alarm, o_ready};
        checks++;
        if (got !== 21'h1) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", got, 21'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_value = 5'b00110;
        tick();
        checks++;
        if ({o_valid, o_value, o_check, o_err_count} !== {1'b1, 5'b00110, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL after_reset: got valid=%0b value=%b check=%0b err=%0d want 1 00110 0 0",
                     o_valid, o_value, o_check, o_err_count);
        end
        i_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_burst_alarm();
        test_backpressure();
        test_saturation();
        test_clear_collision();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
